// File: rtl/battle_turn_ctrl.sv
// Battle turn sequencer: one player half-turn then one AI half-turn per go pulse.
// Define BTC_MISS_EN to enable the roll-versus-accuracy miss check; otherwise every move hits.
module battle_turn_ctrl #(
    parameter int TURN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [3:0]        p_hp,
    input  logic [3:0]        ai_hp,
    input  logic [3:0]        accu,
    input  logic [3:0]        roll,
    output logic              actr,
    output logic              target,
    output logic              stop,
    output logic              load_ai_hp,
    output logic              app_ai_dmg,
    output logic              app_pl_dmg,
    output logic              hit,
    output logic              busy,
    output logic              turn_done,
    output logic              win,
    output logic              lose,
    output logic [TURN_W-1:0] turn_cnt
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_P_SEL   = 4'd1;
    localparam logic [3:0] S_P_LOAD  = 4'd2;
    localparam logic [3:0] S_P_ROLL  = 4'd3;
    localparam logic [3:0] S_P_APPLY = 4'd4;
    localparam logic [3:0] S_P_CHK   = 4'd5;
    localparam logic [3:0] S_A_SEL   = 4'd6;
    localparam logic [3:0] S_A_ROLL  = 4'd7;
    localparam logic [3:0] S_A_APPLY = 4'd8;
    localparam logic [3:0] S_A_CHK   = 4'd9;
    localparam logic [3:0] S_DONE    = 4'd10;
    localparam logic [3:0] S_WIN     = 4'd11;
    localparam logic [3:0] S_LOSE    = 4'd12;

    logic [3:0]        state_r, state_nxt_s;
    logic              hit_r, hit_nxt_s, roll_hit_s;
    logic [TURN_W-1:0] turn_cnt_r, turn_cnt_nxt_s;
    logic              actr_r, target_r, stop_r, load_r, ai_dmg_r, pl_dmg_r;
    logic              busy_r, done_r, win_r, lose_r;
    logic              actr_s, target_s, stop_s, load_s, ai_dmg_s, pl_dmg_s;
    logic              busy_s, done_s, win_s, lose_s;

`ifdef BTC_MISS_EN
    function automatic logic acc_check(input logic [3:0] r, input logic [3:0] a);
        return (r <= a);
    endfunction

    assign roll_hit_s = acc_check(roll, accu);
`else
    logic unused_miss_s;
    assign unused_miss_s = ^{roll, accu};
    assign roll_hit_s    = 1'b1;
`endif

    // Next-state logic for the turn sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:    state_nxt_s = go ? S_P_SEL : S_IDLE;
            S_P_SEL:   state_nxt_s = S_P_LOAD;
            S_P_LOAD:  state_nxt_s = S_P_ROLL;
            S_P_ROLL:  state_nxt_s = S_P_APPLY;
            S_P_APPLY: state_nxt_s = S_P_CHK;
            S_P_CHK:   state_nxt_s = (ai_hp == 4'd0) ? S_WIN : S_A_SEL;
            S_A_SEL:   state_nxt_s = S_A_ROLL;
            S_A_ROLL:  state_nxt_s = S_A_APPLY;
            S_A_APPLY: state_nxt_s = S_A_CHK;
            S_A_CHK:   state_nxt_s = (p_hp == 4'd0) ? S_LOSE : S_DONE;
            S_DONE:    state_nxt_s = S_IDLE;
            S_WIN:     state_nxt_s = S_WIN;
            S_LOSE:    state_nxt_s = S_LOSE;
            default:   state_nxt_s = S_IDLE;
        endcase
    end

    // Hit result and turn counter next values
    always_comb begin
        if ((state_r == S_P_ROLL) || (state_r == S_A_ROLL)) begin
            hit_nxt_s = roll_hit_s;
        end else begin
            hit_nxt_s = hit_r;
        end
        if ((state_nxt_s == S_DONE) && (turn_cnt_r != {TURN_W{1'b1}})) begin
            turn_cnt_nxt_s = turn_cnt_r + TURN_W'(1);
        end else begin
            turn_cnt_nxt_s = turn_cnt_r;
        end
    end

    // Moore decode of the upcoming state so the registered outputs line up with it
    always_comb begin
        actr_s   = 1'b0;
        target_s = 1'b0;
        stop_s   = 1'b0;
        load_s   = 1'b0;
        ai_dmg_s = 1'b0;
        pl_dmg_s = 1'b0;
        done_s   = 1'b0;
        win_s    = 1'b0;
        lose_s   = 1'b0;
        busy_s   = (state_nxt_s != S_IDLE) && (state_nxt_s != S_WIN) && (state_nxt_s != S_LOSE);
        case (state_nxt_s)
            S_P_SEL:   target_s = 1'b1;
            S_P_LOAD:  begin target_s = 1'b1; load_s = 1'b1; end
            S_P_ROLL:  begin target_s = 1'b1; stop_s = 1'b1; end
            S_P_APPLY: begin target_s = 1'b1; ai_dmg_s = hit_nxt_s; end
            S_A_SEL:   begin actr_s = 1'b1; stop_s = 1'b1; end
            S_A_ROLL:  begin actr_s = 1'b1; stop_s = 1'b1; end
            S_A_APPLY: begin actr_s = 1'b1; pl_dmg_s = hit_nxt_s; end
            S_DONE:    done_s = 1'b1;
            S_WIN:     win_s = 1'b1;
            S_LOSE:    lose_s = 1'b1;
            default:   actr_s = 1'b0;
        endcase
    end

    // State, hit, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            hit_r      <= 1'b0;
            turn_cnt_r <= {TURN_W{1'b0}};
            actr_r     <= 1'b0;
            target_r   <= 1'b0;
            stop_r     <= 1'b0;
            load_r     <= 1'b0;
            ai_dmg_r   <= 1'b0;
            pl_dmg_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            win_r      <= 1'b0;
            lose_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hit_r      <= hit_nxt_s;
            turn_cnt_r <= turn_cnt_nxt_s;
            actr_r     <= actr_s;
            target_r   <= target_s;
            stop_r     <= stop_s;
            load_r     <= load_s;
            ai_dmg_r   <= ai_dmg_s;
            pl_dmg_r   <= pl_dmg_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            win_r      <= win_s;
            lose_r     <= lose_s;
        end
    end

    assign actr       = actr_r;
    assign target     = target_r;
    assign stop       = stop_r;
    assign load_ai_hp = load_r;
    assign app_ai_dmg = ai_dmg_r;
    assign app_pl_dmg = pl_dmg_r;
    assign hit        = hit_r;
    assign busy       = busy_r;
    assign turn_done  = done_r;
    assign win        = win_r;
    assign lose       = lose_r;
    assign turn_cnt   = turn_cnt_r;

endmodule

// File: doc/battle_turn_ctrl.md
# battle_turn_ctrl

Turn sequencer for the battle simulator. It sits directly upstream of the battle datapath and drives that datapath's trainer select, RNG freeze, HP-load and damage-apply strobes. It consumes the datapath's HP and accuracy outputs plus a 4-bit accuracy roll to run one player half-turn followed by one AI half-turn per `go` pulse. It flags win or lose and holds there until reset.

## Interface
Parameters:
- `TURN_W`, default 8: width of the turn counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `go` in 1: player has confirmed a move. Sampled only in IDLE.
- `p_hp` in 4: player HP from the datapath.
- `ai_hp` in 4: AI HP from the datapath.
- `accu` in 4: accuracy of the currently selected move, from the datapath.
- `roll` in 4: accuracy RNG value; must be stable while `stop`=1.
- `actr` out 1: trainer select. 0 = player move, 1 = AI RNG move.
- `target` out 1: 0 = player is being hit, 1 = AI is being hit.
- `stop` out 1: freezes the datapath RNGs.
- `load_ai_hp` out 1: one-cycle strobe that snapshots AI HP.
- `app_ai_dmg` out 1: one-cycle strobe that writes AI HP.
- `app_pl_dmg` out 1: one-cycle strobe that writes player HP.
- `hit` out 1: result of the last accuracy check, registered.
- `busy` out 1: high in every state except IDLE, WIN and LOSE.
- `turn_done` out 1: one-cycle pulse at the end of a full turn.
- `win` out 1: AI HP reached 0. Sticky.
- `lose` out 1: player HP reached 0. Sticky.
- `turn_cnt` out TURN_W: number of completed turns, saturating.

## Operation
- All strobe and select outputs are Moore outputs decoded from the state register.
- States, in order: IDLE, P_SEL, P_LOAD, P_ROLL, P_APPLY, P_CHK, A_SEL, A_ROLL, A_APPLY, A_CHK, DONE, WIN, LOSE.
- IDLE → P_SEL when `go`=1; otherwise stay in IDLE.
- **P_SEL:** `actr`=0, `target`=1. This state absorbs the datapath's one-cycle registered trainer mux.
- **P_LOAD:** `actr`=0, `target`=1, `load_ai_hp`=1.
- **P_ROLL:** `actr`=0, `target`=1, `stop`=1. `hit` is registered from the accuracy rule.
- **P_APPLY:** `actr`=0, `target`=1. `app_ai_dmg`=`hit`.
- **P_CHK:** if `ai_hp`==0 → WIN, else → A_SEL.
- **A_SEL:** `actr`=1, `target`=0, `stop`=1. The AI move is latched from the frozen RNG.
- **A_ROLL:** `actr`=1, `target`=0, `stop`=1. `hit` is registered.
- **A_APPLY:** `actr`=1, `target`=0. `app_pl_dmg`=`hit`.
- **A_CHK:** if `p_hp`==0 → LOSE, else → DONE.
- **DONE:** `turn_done`=1; `turn_cnt` increments, saturating at 2^TURN_W−1. Then → IDLE.
- **WIN / LOSE:** terminal. `win` or `lose` is held at 1, all strobes are 0, and `go` is ignored. Only `rst` exits.
- Accuracy rule: hit = (`roll` <= `accu`), unsigned 4-bit compare. `accu`=15 always hits; with `accu`=0, only `roll`=0 hits.
- HP==0 detection uses the value present in the CHK state. This is one cycle after the apply strobe, so the datapath's registered HP has already updated.
- At most one of `load_ai_hp`, `app_ai_dmg`, `app_pl_dmg` is high in any cycle.

## Timing
- Reset (`rst`=0 at a clk edge) takes effect at that edge. After reset: state=IDLE, every output=0, `turn_cnt`=0.
- Reset mid-turn aborts the turn with no further strobes, and clears `win`, `lose` and `turn_cnt`.
- With `go` sampled high at edge 0:
  - P_SEL in cycle 1, P_LOAD in cycle 2, P_ROLL in cycle 3.
  - `app_ai_dmg` in cycle 4, P_CHK in cycle 5.
  - A_SEL in cycle 6, A_ROLL in cycle 7.
  - `app_pl_dmg` in cycle 8, A_CHK in cycle 9.
  - `turn_done` in cycle 10, back in IDLE in cycle 11.
- A full turn is 10 busy cycles. `go` held high continuously starts a new turn every 11 cycles.
- `go` outside IDLE is dropped, not queued.
- `hit` updates at the end of P_ROLL and of A_ROLL, and holds otherwise.

## Configuration
- `BTC_MISS_EN` defined: the accuracy rule above applies, so moves can miss.
- `BTC_MISS_EN` undefined:
  - `hit` is forced to 1, and `roll` is unused.
  - `stop` is still asserted in P_ROLL, A_SEL and A_ROLL.
  - Cycle timing is identical to the defined case.

## Test plan
- **Reset:** rst=0 for 2 cycles → every output 0 and state IDLE. `go` pulsed during reset → ignored.
- **Normal turn:** MISS_EN set, accu=15, roll=9, ai_hp=15, p_hp=15, go pulse → `load_ai_hp` in cycle 2, `app_ai_dmg` in cycle 4, `app_pl_dmg` in cycle 8, `turn_done` in cycle 10, `turn_cnt`=1.
- **Miss:** accu=3, roll=4 → `hit`=0, no `app_ai_dmg` or `app_pl_dmg` pulse, `turn_done` still in cycle 10. Repeat with roll=3 → hit.
- **Win:** ai_hp driven to 0 in cycle 5 → WIN in cycle 6, `win`=1, no AI half-turn strobes. Further `go` pulses are ignored until rst.
- **Lose, then reset mid-turn:** p_hp=0 in cycle 9 → `lose`=1. Then rst=0 during P_ROLL of a new game → IDLE next cycle, no `app_ai_dmg` pulse.
- **Saturation:** TURN_W=2, run 5 turns → `turn_cnt` sticks at 3.
